// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Width of a down-counter that must hold the value bin_w.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Pre-shift correction so the following doubling carries into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// One-bit-per-clock double-dabble converter with start/busy/done handshake,
// saturating to all nines and flagging when the value does not fit DIGITS.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned CW = cnt_width(BIN_W);
  localparam int unsigned BW = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [BW-1:0]      adj_w;
  logic [BW-1:0]      sat_w;
  logic               carry_w;
  logic               fin_w;

  logic               busy_q;
  logic               done_q;
  logic [BW-1:0]      bcd_out_q;
  logic               ovf_out_q;

  // Per-digit correction of the working BCD register and the saturation pattern.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (adj_w[4*g +: 4])
    );
    assign sat_w[4*g +: 4] = BCD_NINE;
  end

  // Next-state logic: accept in IDLE or DONE, one adjust+shift per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    carry_w = 1'b0;
    fin_w   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          shift_d = bin_in;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(BIN_W);
          state_d = S_SHIFT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The bit leaving the top digit means the value no longer fits.
        {carry_w, bcd_d, shift_d} = {adj_w, shift_q, 1'b0};
        ovf_d = ovf_q | carry_w;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          fin_w   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs; the result is loaded only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_out_q <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      busy_q <= (state_d == S_SHIFT);
      done_q <= fin_w;
      if (fin_w) begin
        bcd_out_q <= ovf_d ? sat_w : bcd_d;
        ovf_out_q <= ovf_d;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three configurations (27/8, 8/3, 8/2).
module tb_bin_to_bcd_seq;

  localparam int NDUT = 3;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          done_at;
  } exp_t;

  function automatic int bw(input int i);
    return (i == 0) ? 27 : 8;
  endfunction

  function automatic int nd(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 3 : 2);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [NDUT];
  logic [26:0] bin_v   [NDUT];

  logic        busy0, done0, ovf0;
  logic [31:0] bcd0;
  logic        busy1, done1, ovf1;
  logic [11:0] bcd1;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  exp_t        sb [NDUT][$];
  int          cyc = 0;
  int          last_acc  [NDUT];
  int          next_free [NDUT];
  logic [31:0] last_bcd  [NDUT];
  logic        last_ovf  [NDUT];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(27), .DIGITS(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin_in(bin_v[0]),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0)
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin_in(bin_v[1][7:0]),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1)
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin_in(bin_v[2][7:0]),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  // Reference: decimal digits by div/mod 10, saturated to all nines when too big.
  function automatic void ref_conv(input longint unsigned v, input int d,
                                   output logic [31:0] bcd, output logic ovf);
    longint unsigned lim = 1;
    for (int k = 0; k < d; k++) lim = lim * 10;
    bcd = '0;
    if (v >= lim) begin
      ovf = 1'b1;
      for (int k = 0; k < d; k++) bcd[4*k +: 4] = 4'h9;
    end else begin
      ovf = 1'b0;
      for (int k = 0; k < d; k++) begin
        bcd[4*k +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
  endfunction

  function automatic void outs(input int i, output logic b, output logic d,
                               output logic o, output logic [31:0] c);
    case (i)
      0:       begin b = busy0; d = done0; o = ovf0; c = bcd0; end
      1:       begin b = busy1; d = done1; o = ovf1; c = {20'd0, bcd1}; end
      default: begin b = busy2; d = done2; o = ovf2; c = {24'd0, bcd2}; end
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] got,
                     input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d @edge %0d: got %0h want %0h", nm, i, cyc, got, want);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < NDUT; i++) begin
      sb[i].delete();
      last_acc[i]  = -1000;
      next_free[i] = 0;
      last_bcd[i]  = '0;
      last_ovf[i]  = 1'b0;
    end
  endfunction

  always @(negedge rst_n) clear_model();

  // Model of the handshake: decide which start edges are accepted and queue results.
  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < NDUT; i++) begin
        if (start_v[i] && cyc >= next_free[i]) begin
          exp_t e;
          longint unsigned v;
          v = longint'(bin_v[i]) & ((64'd1 << bw(i)) - 64'd1);
          ref_conv(v, nd(i), e.bcd, e.ovf);
          e.done_at = cyc + bw(i);
          sb[i].push_back(e);
          last_acc[i]  = cyc;
          next_free[i] = cyc + bw(i) + 1;
        end
      end
    end
  end

  // Monitor: compare busy every cycle, results on done, and hold between results.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < NDUT; i++) begin
        logic        b, d, o, exp_busy;
        logic [31:0] c;
        exp_t        e;
        outs(i, b, d, o, c);
        exp_busy = (cyc >= last_acc[i]) && (cyc < last_acc[i] + bw(i));
        chk("busy", i, 64'(b), 64'(exp_busy));
        if (sb[i].size() > 0 && sb[i][0].done_at < cyc) begin
          e = sb[i].pop_front();
          chk("missing_done", i, 64'(cyc), 64'(e.done_at));
        end
        if (d) begin
          if (sb[i].size() == 0) begin
            chk("spurious_done", i, 64'(1), 64'(0));
          end else begin
            e = sb[i].pop_front();
            chk("done_edge", i, 64'(cyc), 64'(e.done_at));
            chk("bcd_out", i, 64'(c), 64'(e.bcd));
            chk("overflow", i, 64'(o), 64'(e.ovf));
            last_bcd[i] = e.bcd;
            last_ovf[i] = e.ovf;
          end
        end else begin
          chk("hold", i, {31'd0, o, c}, {31'd0, last_ovf[i], last_bcd[i]});
        end
      end
    end
  end

  task automatic check_reset(input string nm);
    for (int i = 0; i < NDUT; i++) begin
      logic b, d, o;
      logic [31:0] c;
      outs(i, b, d, o, c);
      chk({nm, "_busy"}, i, 64'(b), 64'(0));
      chk({nm, "_done"}, i, 64'(d), 64'(0));
      chk({nm, "_bcd"},  i, 64'(c), 64'(0));
      chk({nm, "_ovf"},  i, 64'(o), 64'(0));
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (sb[i].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", i, 64'(sb[i].size()), 64'(0));
  endtask

  task automatic conv(input int i, input logic [26:0] v);
    @(negedge clk);
    start_v[i] = 1'b1;
    bin_v[i]   = v;
    @(negedge clk);
    start_v[i] = 1'b0;
    wait_idle(i);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0;
      bin_v[i]   = '0;
    end
    clear_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed values at the default size, including the saturation boundary.
    conv(0, 27'd1234);
    conv(0, 27'd99_999_999);
    conv(0, 27'd100_000_000);
    conv(0, 27'd0);
    conv(0, 27'h7FF_FFFF);

    // Small configurations: overflow structurally absent (3 digits) and present (2 digits).
    conv(1, 27'd255);
    conv(1, 27'd0);
    conv(2, 27'd255);
    conv(2, 27'd99);
    conv(2, 27'd100);
    conv(2, 27'd0);
    for (int n = 0; n < 10; n++) begin
      conv(1, 27'($urandom_range(255)));
      conv(2, 27'($urandom_range(255)));
    end

    // A start pulse while busy must be ignored.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 27'd4321;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 27'd777;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);

    // Start held high with a changing operand: back-to-back conversions.
    @(negedge clk);
    start_v[0] = 1'b1;
    repeat (3 * 28 + 5) begin
      bin_v[0] = 27'($urandom);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of a conversion aborts it without a done pulse.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 27'd5555;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    conv(0, 27'd87_654_321);

    // Random sweep at the default size, back-to-back.
    @(negedge clk);
    start_v[0] = 1'b1;
    repeat (28 * 1000) begin
      bin_v[0] = 27'($urandom);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative (double-dabble) binary-to-BCD converter for the frequency counter display path. It replaces the combinational converter with a one-bit-per-clock engine. Width and digit count are parametrised, it uses a start/busy/done handshake, and it saturates and flags when the count exceeds the displayable range. It sits between the gated-count register and the 7-segment digit mux.

Parameters:
BIN_W, 27, width of the binary input (≥1)
DIGITS, 8, number of BCD output digits (≥1); displayable max = 10^DIGITS − 1

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of bin_in; sampled only when busy=0
bin_in  input  BIN_W  binary value, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd_out/overflow just updated
bcd_out  output  4*DIGITS  result; digit i = bits [4i+3:4i], digit 0 = ones
overflow  output  1  last result exceeded 10^DIGITS − 1

Behaviour:
- Reset (async on rst_n low): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; internal shift/BCD/counter registers cleared. Release is synchronous to clk.
- Clock and reset are the only asynchronous inputs. All outputs are registered.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch bin_in into the shift register, clear the working BCD register and the sticky ovf bit, load cnt=BIN_W, go to SHIFT.
- SHIFT, once per cycle:
  (a) each working digit ≥5 gets +3 (4-bit, no carry between digits);
  (b) {ovf_carry, bcd_work, shift_reg} is shifted left by 1, with the bin MSB entering bcd_work bit 0;
  (c) a 1 shifted out of the top of bcd_work sets sticky ovf;
  (d) cnt−−; when cnt reaches 1 before decrement (last shift), go to DONE.
- DONE (one cycle): done=1. bcd_out = ovf ? all digits 4'h9 : bcd_work. overflow = ovf. Then go to IDLE.
- busy=1 exactly in SHIFT. busy=0 in IDLE and DONE.
- Latency: start accepted at edge k → busy high for cycles k+1..k+BIN_W → done high in cycle k+BIN_W+1, with bcd_out valid from that same edge.
- start while busy=1: ignored; bin_in is not re-captured.
- start during the DONE cycle: accepted. DONE → SHIFT directly with the new operand. done still pulses for the old result. Back-to-back throughput = one conversion per BIN_W+1 cycles.
- bcd_out/overflow hold their last value until the next DONE. They never show intermediate values.
- Reset mid-conversion: abort; no done pulse; outputs return to reset values.
- Width rules:
  - cnt width = $clog2(BIN_W+1).
  - Adjust is applied before shift, matching classic double-dabble; no adjust is applied after the final shift.
  - If DIGITS is large enough that 2^BIN_W − 1 < 10^DIGITS, overflow is structurally 0. It must still be driven, constant 0 via the same logic.
- bin_in value of 0 is legal: BIN_W shift cycles still run (fixed latency, no early exit).

Decomposition:
- Package bin_to_bcd_pkg:
  - state typedef (IDLE/SHIFT/DONE);
  - localparam BCD_NINE = 4'h9;
  - function for counter width.
- Sub-module bcd_digit_adj: combinational 4-bit "add 3 if ≥5". Instantiated DIGITS times via generate inside bin_to_bcd_seq.
- FSM, counter, shift registers and output registers live in bin_to_bcd_seq.

Test Plan:
1. Defaults, bin_in=1234, start pulse at cycle 0 → busy cycles 1–27, done pulse at cycle 28, bcd_out=32'h00001234, overflow=0.
2. Defaults, bin_in=99_999_999 → bcd_out=32'h99999999, overflow=0. Then bin_in=100_000_000 → bcd_out=32'h99999999, overflow=1. Then bin_in=0 → bcd_out=0, overflow=0 (flag clears).
3. Start held high continuously with bin_in changing every cycle → only the value present on accepting edges is converted. A start pulse during busy is ignored. A start during the done cycle begins the next conversion: second done exactly 28 cycles after the first.
4. Assert rst_n=0 at cycle 10 of a conversion → busy=0, done never pulses, bcd_out=0, overflow=0 immediately (asynchronous). A new start after release converts correctly.
5. BIN_W=8, DIGITS=3: bin_in=255 → bcd_out=12'h255, done at cycle 9. BIN_W=8, DIGITS=2: 255 → bcd_out=8'h99, overflow=1. 99 → 8'h99, overflow=0.
6. Random sweep, 1000 values at defaults → bcd_out matches reference model (per-digit div/mod 10, saturated) and latency is always BIN_W+1.
